id_lexer: RTL and testbench
===========================

# id_lexer

Streaming token recogniser for 8-bit character streams. Extends the single-output identifier FSM into a parametrised lexer. It classifies each accepted character, tracks identifiers, numbers and malformed tokens, and emits one token descriptor (type, length) per completed token over a valid/ready handshake. It sits between the character source (UART/keyboard front end) and the parser stage. It also keeps the legacy `out` flag for existing consumers.

## Interface
- `CHAR_W`, 8: character width; the classification ranges are ASCII.
- `MAX_LEN`, 16: maximum legal token length; a longer token becomes ERR.
- `ALLOW_UNDERSCORE`, 1: 1 = `_` (0x5F) counts as a letter; 0 = delimiter.
- `LEN_W`, $clog2(MAX_LEN+1): width of the length field (derived, not overridden).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `char`  in  CHAR_W  input character.
- `in_valid`  in  1  `char` is valid this cycle.
- `in_last`  in  1  the current beat is the last of the stream.
- `in_ready`  out  1  the lexer accepts a beat this cycle.
- `tok_valid`  out  1  the token descriptor is valid.
- `tok_ready`  in  1  the consumer takes the descriptor.
- `tok_type`  out  2  0 = ID, 1 = NUM, 2 = ERR (3 is never driven).
- `tok_len`  out  LEN_W  token length in characters, saturating at MAX_LEN.
- `out`  out  1  legacy flag: the last accepted char was a digit inside an identifier.

## Operation
- Accept: `in_valid && in_ready`. All state updates happen only on accept.
- `in_ready = !tok_valid || tok_ready`. This is a one-entry output register with no bubble.
- Character classes:
  - ALPHA = 0x41–0x5A, 0x61–0x7A, plus 0x5F if ALLOW_UNDERSCORE.
  - DIGIT = 0x30–0x39.
  - DELIM = everything else.
- State machine, with `len` counting characters:
  - IDLE:
    - ALPHA → IDENT, len = 1.
    - DIGIT → NUMBER, len = 1.
    - DELIM → IDLE.
  - IDENT:
    - ALPHA or DIGIT → IDENT, len + 1.
    - DELIM → emit ID(len), then IDLE.
  - NUMBER:
    - DIGIT → NUMBER, len + 1.
    - ALPHA → BAD, len + 1.
    - DELIM → emit NUM(len), then IDLE.
  - BAD:
    - ALPHA or DIGIT → BAD, len saturating.
    - DELIM → emit ERR(len), then IDLE.
- Overflow: in IDENT or NUMBER with len == MAX_LEN, a body character moves the FSM to BAD and len stays at MAX_LEN.
- `in_last` on a body character: that character is included, the current token is emitted (ERR if that character overflowed or made the token malformed), and the FSM goes to IDLE.
- `in_last` on a DELIM character: normal processing, then IDLE.
- `in_last` in IDLE on a DELIM character: no emission.
- A DELIM character never contributes to `len`.
- `out` on accept:
  - set to 1 iff the character is DIGIT and the pre-accept state is IDENT;
  - otherwise set to 0.
  - It holds its value between accepts.

## Timing
- Reset values: state IDLE, len 0, `tok_valid` 0, `tok_type` 0, `tok_len` 0, `out` 0. `in_ready` reads 1 during and after reset.
- Reset mid-token: the partial token is discarded and no descriptor is emitted.
- Token latency: `tok_valid` rises the cycle after the terminating beat is accepted.
- `tok_type` and `tok_len` are stable while `tok_valid && !tok_ready`.
- `tok_valid` clears the cycle after `tok_ready` is sampled high, unless a new emission happens in the same cycle. In that case the register reloads and `tok_valid` stays 1, which sustains back-to-back tokens with no stall.
- `out` is updated one cycle after the accept, the same edge as the state update.
- Throughput: one character per cycle while the consumer keeps `tok_ready` high.

## Structure
- Package `id_lexer_pkg`:
  - state enum {IDLE, IDENT, NUMBER, BAD};
  - token type constants TOK_ID, TOK_NUM, TOK_ERR;
  - class enum {C_ALPHA, C_DIGIT, C_DELIM};
  - ASCII range constants.
- Sub-module `char_class`: purely combinational. Maps `char` plus ALLOW_UNDERSCORE to a class.
- Top level holds the FSM, the saturating length counter and the output register.

## Test plan
- Stream "ab12 " with `tok_ready`=1:
  - one token, ID, len 4, valid the cycle after the space is accepted;
  - `out` sequence 0,0,1,1,0.
- Stream "123;x9" with `in_last` on '9':
  - NUM len 3 after ';';
  - then ID len 2 after '9'.
- Stream "12ab " → one ERR token, len 4.
- MAX_LEN=4, stream "abcdef " → ERR token with len 4.
- Hold `tok_ready`=0 after the first token of "a b " → `in_ready` drops, the descriptor holds ID/1, and no beat is lost. Releasing `tok_ready` delivers ID/1 then ID/1.
- Assert `rst_n` low mid "abc" → outputs return to their reset values immediately, with no emission. Then stream "9 " → NUM len 1.

Source files
------------

// File: rtl/id_lexer_pkg.sv
// rtl/id_lexer_pkg.sv - shared types and ASCII constants for the identifier/number lexer
package id_lexer_pkg;

    typedef enum logic [1:0] {IDLE, IDENT, NUMBER, BAD} state_t;
    typedef enum logic [1:0] {C_ALPHA, C_DIGIT, C_DELIM} cls_t;

    localparam logic [1:0] TOK_ID  = 2'd0;
    localparam logic [1:0] TOK_NUM = 2'd1;
    localparam logic [1:0] TOK_ERR = 2'd2;

    localparam logic [7:0] ASCII_UPPER_A    = 8'h41;
    localparam logic [7:0] ASCII_UPPER_Z    = 8'h5A;
    localparam logic [7:0] ASCII_LOWER_A    = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z    = 8'h7A;
    localparam logic [7:0] ASCII_DIGIT_0    = 8'h30;
    localparam logic [7:0] ASCII_DIGIT_9    = 8'h39;
    localparam logic [7:0] ASCII_UNDERSCORE = 8'h5F;

    // Token type reported when a token in state s is closed.
    function automatic logic [1:0] tok_type_of(input state_t s);
        case (s)
            IDENT:   return TOK_ID;
            NUMBER:  return TOK_NUM;
            default: return TOK_ERR;
        endcase
    endfunction

endpackage

// File: rtl/id_lexer_char_class.sv
// rtl/id_lexer_char_class.sv - combinational ASCII character classifier
module char_class
    import id_lexer_pkg::*;
#(
    parameter int CHAR_W           = 8,
    parameter bit ALLOW_UNDERSCORE = 1'b1
) (
    input  logic [CHAR_W-1:0] char_in,
    output cls_t              cls
);

    logic is_upper;
    logic is_lower;
    logic is_under;
    logic is_digit;

    always_comb begin
        is_upper = (char_in >= CHAR_W'(ASCII_UPPER_A)) && (char_in <= CHAR_W'(ASCII_UPPER_Z));
        is_lower = (char_in >= CHAR_W'(ASCII_LOWER_A)) && (char_in <= CHAR_W'(ASCII_LOWER_Z));
        is_under = ALLOW_UNDERSCORE && (char_in == CHAR_W'(ASCII_UNDERSCORE));
        is_digit = (char_in >= CHAR_W'(ASCII_DIGIT_0)) && (char_in <= CHAR_W'(ASCII_DIGIT_9));
        if (is_upper || is_lower || is_under) begin
            cls = C_ALPHA;
        end else if (is_digit) begin
            cls = C_DIGIT;
        end else begin
            cls = C_DELIM;
        end
    end

endmodule

// File: rtl/id_lexer.sv
// rtl/id_lexer.sv - streaming ID/NUM/ERR token recogniser with one-entry descriptor register
module id_lexer
    import id_lexer_pkg::*;
#(
    parameter int CHAR_W           = 8,
    parameter int MAX_LEN          = 16,
    parameter bit ALLOW_UNDERSCORE = 1'b1,
    localparam int LEN_W           = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CHAR_W-1:0] char_in,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              tok_valid,
    input  logic              tok_ready,
    output logic [1:0]        tok_type,
    output logic [LEN_W-1:0]  tok_len,
    output logic              out
);

    cls_t             cls;
    state_t           state_q, state_d, nstate;
    logic [LEN_W-1:0] len_q, len_d, nlen, len_inc, emit_len;
    logic [LEN_W-1:0] tok_len_q, tok_len_d;
    logic [1:0]       tok_type_q, tok_type_d, emit_type;
    logic             tok_valid_q, tok_valid_d;
    logic             out_q, out_d;
    logic             accept, body, len_full, emit;

    char_class #(
        .CHAR_W           (CHAR_W),
        .ALLOW_UNDERSCORE (ALLOW_UNDERSCORE)
    ) u_char_class (
        .char_in (char_in),
        .cls     (cls)
    );

    assign in_ready  = !tok_valid_q || tok_ready;
    assign accept    = in_valid && in_ready;
    assign tok_valid = tok_valid_q;
    assign tok_type  = tok_type_q;
    assign tok_len   = tok_len_q;
    assign out       = out_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        out_d       = out_q;
        tok_valid_d = tok_valid_q && !tok_ready;
        tok_type_d  = tok_type_q;
        tok_len_d   = tok_len_q;
        nstate      = state_q;
        nlen        = len_q;
        emit        = 1'b0;
        emit_type   = TOK_ID;
        emit_len    = len_q;
        body        = (cls != C_DELIM);
        len_full    = (len_q == LEN_W'(MAX_LEN));
        len_inc     = len_full ? len_q : len_q + LEN_W'(1);

        if (accept) begin
            out_d = (cls == C_DIGIT) && (state_q == IDENT);
            if (!body) begin
                emit      = (state_q != IDLE);
                emit_type = tok_type_of(state_q);
                emit_len  = len_q;
                nstate    = IDLE;
                nlen      = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        nstate = (cls == C_ALPHA) ? IDENT : NUMBER;
                        nlen   = LEN_W'(1);
                    end
                    IDENT: begin
                        nstate = len_full ? BAD : IDENT;
                        nlen   = len_inc;
                    end
                    NUMBER: begin
                        nstate = (cls == C_DIGIT && !len_full) ? NUMBER : BAD;
                        nlen   = len_inc;
                    end
                    default: begin
                        nstate = BAD;
                        nlen   = len_inc;
                    end
                endcase
                // A last body beat closes the token it just joined.
                if (in_last) begin
                    emit      = 1'b1;
                    emit_type = tok_type_of(nstate);
                    emit_len  = nlen;
                    nstate    = IDLE;
                    nlen      = '0;
                end
            end
            state_d = nstate;
            len_d   = nlen;
            if (emit) begin
                tok_valid_d = 1'b1;
                tok_type_d  = emit_type;
                tok_len_d   = emit_len;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            out_q       <= 1'b0;
            tok_valid_q <= 1'b0;
            tok_type_q  <= TOK_ID;
            tok_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            out_q       <= out_d;
            tok_valid_q <= tok_valid_d;
            tok_type_q  <= tok_type_d;
            tok_len_q   <= tok_len_d;
        end
    end

endmodule

// File: tb/tb_id_lexer.sv
// tb/tb_id_lexer.sv - directed self-checking bench for id_lexer
module tb_id_lexer;

    logic       clk;
    logic       rst_n;
    logic [7:0] char_in;
    logic       in_valid;
    logic       in_last;
    logic       tok_ready;
    logic       in_ready;
    logic       tok_valid;
    logic [1:0] tok_type;
    logic [4:0] tok_len;
    logic       out;

    logic       in_ready4;
    logic       tok_valid4;
    logic [1:0] tok_type4;
    logic [2:0] tok_len4;
    logic       out4;

    int checks;
    int failures;

    id_lexer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .char_in   (char_in),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok_type  (tok_type),
        .tok_len   (tok_len),
        .out       (out)
    );

    id_lexer #(.MAX_LEN(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .char_in   (char_in),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready4),
        .tok_valid (tok_valid4),
        .tok_ready (tok_ready),
        .tok_type  (tok_type4),
        .tok_len   (tok_len4),
        .out       (out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic last);
        char_in  = c;
        in_valid = 1'b1;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++;
        if (tok_valid !== 1'b0 || tok_type !== 2'd0 || tok_len !== 5'd0 || out !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got=v%0b t%0d l%0d o%0b exp=v0 t0 l0 o0", tok_valid, tok_type, tok_len, out);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_ident();
        logic [7:0] s [5];
        logic       exp_out [5];
        s = '{8'h61, 8'h62, 8'h31, 8'h32, 8'h20};
        exp_out = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            send(s[i], 1'b0);
            checks++;
            if (out !== exp_out[i]) begin failures++; $display("FAIL ab12_out[%0d] got=%0b exp=%0b", i, out, exp_out[i]); end
            if (i < 4) begin
                checks++;
                if (tok_valid !== 1'b0) begin failures++; $display("FAIL ab12_early_valid[%0d] got=%0b exp=0", i, tok_valid); end
            end
        end
        checks++;
        if (tok_valid !== 1'b1 || tok_type !== 2'd0 || tok_len !== 5'd4) begin
            failures++;
            $display("FAIL ab12_token got=v%0b t%0d l%0d exp=v1 t0 l4", tok_valid, tok_type, tok_len);
        end
        step();
        checks++;
        if (tok_valid !== 1'b0) begin failures++; $display("FAIL ab12_drain got=%0b exp=0", tok_valid); end
    endtask

    task automatic test_num_last();
        send(8'h31, 1'b0);
        send(8'h32, 1'b0);
        send(8'h33, 1'b0);
        send(8'h3B, 1'b0);
        checks++;
        if (tok_valid !== 1'b1 || tok_type !== 2'd1 || tok_len !== 5'd3) begin
            failures++;
            $display("FAIL num123_token got=v%0b t%0d l%0d exp=v1 t1 l3", tok_valid, tok_type, tok_len);
        end
        send(8'h78, 1'b0);
        checks++;
        if (tok_valid !== 1'b0) begin failures++; $display("FAIL num123_clear got=%0b exp=0", tok_valid); end
        send(8'h39, 1'b1);
        checks++;
        if (tok_valid !== 1'b1 || tok_type !== 2'd0 || tok_len !== 5'd2 || out !== 1'b1) begin
            failures++;
            $display("FAIL x9_last_token got=v%0b t%0d l%0d o%0b exp=v1 t0 l2 o1", tok_valid, tok_type, tok_len, out);
        end
        step();
    endtask

    task automatic test_malformed();
        send(8'h31, 1'b0);
        send(8'h32, 1'b0);
        send(8'h61, 1'b0);
        checks++;
        if (out !== 1'b0) begin failures++; $display("FAIL 12ab_out got=%0b exp=0", out); end
        send(8'h62, 1'b0);
        send(8'h20, 1'b0);
        checks++;
        if (tok_valid !== 1'b1 || tok_type !== 2'd2 || tok_len !== 5'd4) begin
            failures++;
            $display("FAIL 12ab_token got=v%0b t%0d l%0d exp=v1 t2 l4", tok_valid, tok_type, tok_len);
        end
        step();
    endtask

    task automatic test_overflow();
        logic [7:0] s [7];
        s = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h20};
        for (int i = 0; i < 7; i++) send(s[i], 1'b0);
        checks++;
        if (tok_valid4 !== 1'b1 || tok_type4 !== 2'd2 || tok_len4 !== 3'd4) begin
            failures++;
            $display("FAIL max4_token got=v%0b t%0d l%0d exp=v1 t2 l4", tok_valid4, tok_type4, tok_len4);
        end
        checks++;
        if (tok_valid !== 1'b1 || tok_type !== 2'd0 || tok_len !== 5'd6) begin
            failures++;
            $display("FAIL max16_token got=v%0b t%0d l%0d exp=v1 t0 l6", tok_valid, tok_type, tok_len);
        end
        step();
    endtask

    task automatic test_underscore();
        send(8'h5F, 1'b0);
        send(8'h61, 1'b0);
        send(8'h20, 1'b0);
        checks++;
        if (tok_valid !== 1'b1 || tok_type !== 2'd0 || tok_len !== 5'd2) begin
            failures++;
            $display("FAIL underscore_token got=v%0b t%0d l%0d exp=v1 t0 l2", tok_valid, tok_type, tok_len);
        end
        step();
    endtask

    task automatic test_backpressure();
        tok_ready = 1'b0;
        send(8'h61, 1'b0);
        send(8'h20, 1'b0);
        checks++;
        if (tok_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall got=v%0b r%0b exp=v1 r0", tok_valid, in_ready);
        end
        char_in  = 8'h62;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (tok_valid !== 1'b1 || tok_type !== 2'd0 || tok_len !== 5'd1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold got=v%0b t%0d l%0d r%0b exp=v1 t0 l1 r0", tok_valid, tok_type, tok_len, in_ready);
        end
        tok_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
        step();
        checks++;
        if (tok_valid !== 1'b0) begin failures++; $display("FAIL bp_first_taken got=%0b exp=0", tok_valid); end
        char_in = 8'h20;
        step();
        in_valid = 1'b0;
        checks++;
        if (tok_valid !== 1'b1 || tok_type !== 2'd0 || tok_len !== 5'd1) begin
            failures++;
            $display("FAIL bp_second_token got=v%0b t%0d l%0d exp=v1 t0 l1", tok_valid, tok_type, tok_len);
        end
        step();
        checks++;
        if (tok_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0b exp=0", tok_valid); end
    endtask

    task automatic test_reset_mid_token();
        send(8'h61, 1'b0);
        send(8'h31, 1'b0);
        checks++;
        if (out !== 1'b1) begin failures++; $display("FAIL midrst_pre_out got=%0b exp=1", out); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tok_valid !== 1'b0 || tok_type !== 2'd0 || tok_len !== 5'd0 || out !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_async got=v%0b t%0d l%0d o%0b r%0b exp=v0 t0 l0 o0 r1",
                     tok_valid, tok_type, tok_len, out, in_ready);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (tok_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_emit got=%0b exp=0", tok_valid); end
        send(8'h39, 1'b0);
        send(8'h20, 1'b0);
        checks++;
        if (tok_valid !== 1'b1 || tok_type !== 2'd1 || tok_len !== 5'd1) begin
            failures++;
            $display("FAIL midrst_num_token got=v%0b t%0d l%0d exp=v1 t1 l1", tok_valid, tok_type, tok_len);
        end
        step();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        char_in   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        tok_ready = 1'b1;
        test_reset();
        test_ident();
        test_num_last();
        test_malformed();
        test_overflow();
        test_underscore();
        test_backpressure();
        test_reset_mid_token();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
